// File: rtl/vec_serializer_if.sv
// Vector-in / element-stream-out handshake bundle for vec_serializer.
// slave is the serializer's view, master is the environment driving vectors and consuming beats.
interface vec_serializer_if #(
  parameter int unsigned NUM_ELEM = 10,
  parameter int unsigned ELEM_W   = 32
);
  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_ELEM*ELEM_W-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [ELEM_W-1:0]          out_data;
  logic [IDX_W-1:0]           out_index;
  logic                       out_last;
  logic                       busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/vec_serializer.sv
// Captures a NUM_ELEM-element vector and streams it out index 0 first, one element per beat.
// Optional VEC_SERIALIZER_SUM_EN appends a modulo-2^ELEM_W sum beat after the last element.
module vec_serializer #(
  parameter int unsigned NUM_ELEM = 10,
  parameter int unsigned ELEM_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  vec_serializer_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int unsigned VEC_W = NUM_ELEM * ELEM_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
`ifdef VEC_SERIALIZER_SUM_EN
  localparam logic [1:0] S_SUM    = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [ELEM_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
`ifdef VEC_SERIALIZER_SUM_EN
  logic [ELEM_W-1:0] acc_q, acc_d;
`endif

  logic [IDX_W-1:0]  idx_nxt;
  logic [ELEM_W-1:0] elem_cur, elem_nxt;
  logic              beat_c, in_ready_c, capture_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef VEC_SERIALIZER_SUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef VEC_SERIALIZER_SUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // Next-state, handshake and output-register update
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef VEC_SERIALIZER_SUM_EN
    acc_d       = acc_q;
`endif
    idx_nxt    = idx_q + IDX_W'(1);
    elem_cur   = vec_q[int'(idx_q) * ELEM_W +: ELEM_W];
    elem_nxt   = vec_q[int'(idx_nxt) * ELEM_W +: ELEM_W];
    beat_c     = out_valid_q & bus.out_ready;
    in_ready_c = (state_q == S_IDLE) | (beat_c & out_last_q);
    capture_c  = bus.in_valid & in_ready_c;

    case (state_q)
      S_STREAM: begin
        if (beat_c) begin
          if (idx_q == LAST_IDX) begin
`ifdef VEC_SERIALIZER_SUM_EN
            state_d    = S_SUM;
            acc_d      = acc_q + elem_cur;
            out_data_d = acc_q + elem_cur;
            out_last_d = 1'b1;
`else
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`endif
          end else begin
            idx_d      = idx_nxt;
            out_data_d = elem_nxt;
`ifdef VEC_SERIALIZER_SUM_EN
            acc_d      = acc_q + elem_cur;
            out_last_d = 1'b0;
`else
            out_last_d = (idx_nxt == LAST_IDX);
`endif
          end
        end
      end
`ifdef VEC_SERIALIZER_SUM_EN
      S_SUM: begin
        if (beat_c) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    // A capture only occurs from IDLE or on the final beat, so it always restarts the stream
    if (capture_c) begin
      state_d     = S_STREAM;
      vec_d       = bus.in_data;
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[ELEM_W-1:0];
      out_last_d  = 1'b0;
`ifdef VEC_SERIALIZER_SUM_EN
      acc_d       = '0;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_vec_serializer.sv
// Randomized self-checking bench for vec_serializer against a beat-queue reference model.
module tb_vec_serializer;
  localparam int unsigned NUM_ELEM = 10;
  localparam int unsigned ELEM_W   = 32;
  localparam int unsigned VEC_W    = NUM_ELEM * ELEM_W;

  typedef struct {
    logic [ELEM_W-1:0] d;
    int                idx;
    bit                last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_cap;
  beat_t q[$];

  vec_serializer_if #(.NUM_ELEM(NUM_ELEM), .ELEM_W(ELEM_W)) bus ();

  vec_serializer #(.NUM_ELEM(NUM_ELEM), .ELEM_W(ELEM_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat sequence of one vector, straight from the element/sum rules
  task automatic push_vec(input logic [VEC_W-1:0] v);
    beat_t b;
    logic [ELEM_W-1:0] sum = '0;
    for (int i = 0; i < int'(NUM_ELEM); i++) begin
      b.d    = v[i*ELEM_W +: ELEM_W];
      b.idx  = i;
`ifdef VEC_SERIALIZER_SUM_EN
      b.last = 1'b0;
`else
      b.last = (i == int'(NUM_ELEM) - 1);
`endif
      sum += b.d;
      q.push_back(b);
    end
`ifdef VEC_SERIALIZER_SUM_EN
    b.d = sum; b.idx = int'(NUM_ELEM) - 1; b.last = 1'b1;
    q.push_back(b);
`endif
  endtask

  // One clock: check at negedge, advance the model at posedge
  task automatic step();
    bit exp_ready, xfer, cap;
    @(negedge clk);
    exp_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    if (q.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].d));
      chk("out_index", 64'(bus.out_index), 64'(q[0].idx));
      chk("out_last", 64'(bus.out_last), 64'(q[0].last));
    end
    xfer = (q.size() != 0) && bus.out_ready;
    cap  = bus.in_valid && exp_ready;
    @(posedge clk);
    if (xfer) void'(q.pop_front());
    if (cap) push_vec(bus.in_data);
    last_cap = cap;
    #1;
  endtask

  task automatic send(input logic [VEC_W-1:0] v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    do begin step(); n++; end while (!last_cap && n < 200);
    if (!last_cap) chk("capture_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin step(); n++; end
    chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(q.size() != 0 && q[0].idx == idx && !q[0].last) && n < 100) begin step(); n++; end
    chk("wait_idx_timeout", 64'(q.size() != 0 && q[0].idx == idx), 64'(1));
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < int'(NUM_ELEM); i++) v[i*ELEM_W +: ELEM_W] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VEC_W-1:0] v_ramp, v_ones, v_tmp;
    int pat[4] = '{1, 0, 0, 1};
    int k;

    for (int i = 0; i < int'(NUM_ELEM); i++) v_ramp[i*ELEM_W +: ELEM_W] = ELEM_W'(i * 3);
    v_ones = '1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_index", 64'(bus.out_index), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) step();

    // Single ramp vector at full throughput
    send(v_ramp);
    drain();

    // Backpressure 1,0,0,1
    bus.in_valid = 1'b1;
    bus.in_data  = v_ramp;
    k = 0;
    do begin bus.out_ready = pat[k % 4][0]; step(); k++; end while (!last_cap && k < 50);
    bus.in_valid = 1'b0;
    while (q.size() != 0 && k < 200) begin bus.out_ready = pat[k % 4][0]; step(); k++; end
    chk("bp_drain", 64'(q.size()), 64'(0));
    bus.out_ready = 1'b1;

    // Back-to-back: second vector held valid until taken on the final beat
    send(v_ramp);
    send(v_ones);
    drain();

    // Ignored pulse at index 4
    send(v_ramp);
    wait_idx(4);
    bus.in_valid = 1'b1;
    bus.in_data  = rand_vec();
    step();
    chk("pulse_dropped", 64'(last_cap), 64'(0));
    bus.in_valid = 1'b0;
    drain();

    // Async reset between edges at index 5
    send(v_ramp);
    wait_idx(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_index", 64'(bus.out_index), 64'(0));
    chk("arst_out_data", 64'(bus.out_data), 64'(0));
    chk("arst_out_last", 64'(bus.out_last), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    q.delete();
    step();
    step();
    rst = 1'b0;
    v_tmp = rand_vec();
    send(v_tmp);
    drain();

    // Random traffic with random backpressure
    for (int n = 0; n < 30; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_vec();
      k = 0;
      do begin bus.out_ready = 1'($urandom_range(0, 1)); step(); k++; end while (!last_cap && k < 300);
      if (!last_cap) chk("rand_cap_timeout", 64'(0), 64'(1));
      bus.in_valid = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 12)); g++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
